// File: rtl/isa_defs.sv
// isa_defs: opcode map, IR field positions and fetch FSM encoding
// shared by the fetch sequencer and its branch evaluator.
package isa_defs;

  localparam int OPC_W   = 5;
  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 27;

  typedef logic [OPC_W-1:0] opc_t;

  // 00000..01011 are execute-unit ops
  localparam opc_t OP_ALU_LAST = 5'b01011;
  localparam opc_t OP_JMP = 5'b01100;
  localparam opc_t OP_JC  = 5'b01101;
  localparam opc_t OP_JNC = 5'b01110;
  localparam opc_t OP_JS  = 5'b01111;
  localparam opc_t OP_JNS = 5'b10000;
  localparam opc_t OP_JZ  = 5'b10001;
  localparam opc_t OP_JNZ = 5'b10010;
  localparam opc_t OP_JV  = 5'b10011;
  localparam opc_t OP_JNV = 5'b10100;
  localparam opc_t OP_HLT = 5'b10111;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_ISSUE  = 3'd3,
    ST_WAITF  = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

  typedef struct packed {
    logic sign;
    logic zero;
    logic carry;
    logic ovf;
  } flags_t;

  function automatic logic is_cond(input opc_t op);
    return (op >= OP_JC) && (op <= OP_JNV);
  endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// branch_cond_eval: jump opcode plus execute flags -> taken.
// Purely combinational; non-jump opcodes report not taken.
module branch_cond_eval
  import isa_defs::*;
(
  input  opc_t   i_opc,
  input  flags_t i_flags,
  output logic   o_taken
);

  always_comb begin
    o_taken = 1'b0;
    unique case (1'b1)
      (i_opc == OP_JMP): o_taken = 1'b1;
      (i_opc == OP_JC):  o_taken = i_flags.carry;
      (i_opc == OP_JNC): o_taken = ~i_flags.carry;
      (i_opc == OP_JS):  o_taken = i_flags.sign;
      (i_opc == OP_JNS): o_taken = ~i_flags.sign;
      (i_opc == OP_JZ):  o_taken = i_flags.zero;
      (i_opc == OP_JNZ): o_taken = ~i_flags.zero;
      (i_opc == OP_JV):  o_taken = i_flags.ovf;
      (i_opc == OP_JNV): o_taken = ~i_flags.ovf;
      default:           o_taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_fetch_seq.sv
// instr_fetch_seq: fetches from sync imem, issues ops to execute,
// resolves jumps/halt locally using flags returned by execute.
module instr_fetch_seq
  import isa_defs::*;
#(
  parameter int                ADDR_W     = 8,
  parameter logic [ADDR_W-1:0] START_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              imem_rd_en,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       ir,
  output logic              ir_valid,
  input  logic              ir_ready,
  input  logic              ex_done,
  input  logic              flag_sign,
  input  logic              flag_zero,
  input  logic              flag_carry,
  input  logic              flag_overflow,
  output logic [ADDR_W-1:0] pc,
  output logic              halted,
  output logic              busy
);

  state_t            r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [31:0]       r_ir;
  logic              r_ir_valid;
  logic              r_rd_en;
  logic              r_halted;
  logic              r_busy;
  logic              r_out;
  logic              r_dec_hold;
  flags_t            r_flags;

  state_t            w_nxt;
  logic [ADDR_W-1:0] w_pc_nxt;
  logic [ADDR_W-1:0] w_pc_inc;
  logic [31:0]       w_word;
  opc_t              w_opc;
  logic              w_done;
  logic              w_out_eff;
  logic              w_hs;
  logic              w_taken;
  flags_t            w_flags_in;
  flags_t            w_flags;

  assign w_flags_in = '{sign:  flag_sign,
                        zero:  flag_zero,
                        carry: flag_carry,
                        ovf:   flag_overflow};

  // ex_done only counts when something is actually in flight
  assign w_done    = ex_done & r_out;
  assign w_out_eff = r_out & ~ex_done;
  assign w_flags   = w_done ? w_flags_in : r_flags;
  assign w_hs      = r_ir_valid & ir_ready;
  assign w_pc_inc  = r_pc + 1'b1;

  // a stalled DECODE keeps using the captured word, not stale rdata
  assign w_word = r_dec_hold ? r_ir : imem_rdata;
  assign w_opc  = w_word[OPC_MSB:OPC_LSB];

  branch_cond_eval u_bce (
    .i_opc   (r_ir[OPC_MSB:OPC_LSB]),
    .i_flags (w_flags),
    .o_taken (w_taken)
  );

  always_comb begin
    w_nxt    = r_state;
    w_pc_nxt = r_pc;
    unique case (r_state)
      ST_IDLE, ST_HALT: begin
        if (start) begin
          w_nxt    = ST_FETCH;
          w_pc_nxt = START_ADDR;
        end
      end
      ST_FETCH: w_nxt = ST_DECODE;
      ST_DECODE: begin
        unique case (1'b1)
          (w_opc == OP_HLT): w_nxt = ST_HALT;
          (w_opc == OP_JMP): begin
            w_nxt    = ST_FETCH;
            w_pc_nxt = w_word[ADDR_W-1:0];
          end
          is_cond(w_opc): w_nxt = ST_WAITF;
          default: begin
            if (!w_out_eff) w_nxt = ST_ISSUE;
          end
        endcase
      end
      ST_ISSUE: begin
        if (w_hs) begin
          w_nxt    = ST_FETCH;
          w_pc_nxt = w_pc_inc;
        end
      end
      ST_WAITF: begin
        if (!w_out_eff) begin
          w_nxt    = ST_FETCH;
          w_pc_nxt = w_taken ? r_ir[ADDR_W-1:0] : w_pc_inc;
        end
      end
      default: w_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_pc       <= START_ADDR;
      r_ir       <= '0;
      r_ir_valid <= 1'b0;
      r_rd_en    <= 1'b0;
      r_halted   <= 1'b0;
      r_busy     <= 1'b0;
      r_out      <= 1'b0;
      r_dec_hold <= 1'b0;
      r_flags    <= '0;
    end else begin
      r_state    <= w_nxt;
      r_pc       <= w_pc_nxt;
      if (r_state == ST_DECODE) r_ir <= w_word;
      r_dec_hold <= (r_state == ST_DECODE) && (w_nxt == ST_DECODE);
      r_ir_valid <= (w_nxt == ST_ISSUE);
      r_rd_en    <= (w_nxt == ST_FETCH);
      r_halted   <= (w_nxt == ST_HALT);
      r_busy     <= (w_nxt != ST_IDLE) && (w_nxt != ST_HALT);
      // a handshake wins over a same-cycle retire
      if (w_hs)
        r_out <= 1'b1;
      else if (ex_done)
        r_out <= 1'b0;
      if (w_done) r_flags <= w_flags_in;
    end
  end

  assign imem_rd_en = r_rd_en;
  assign imem_addr  = r_pc;
  assign pc         = r_pc;
  assign ir         = r_ir;
  assign ir_valid   = r_ir_valid;
  assign halted     = r_halted;
  assign busy       = r_busy;

endmodule

// File: tb/tb_instr_fetch_seq.sv
// tb_instr_fetch_seq: directed scoreboard bench for instr_fetch_seq
// with a sync imem model and a small execute responder.
module tb_instr_fetch_seq;

  localparam logic [4:0] T_ADD = 5'b00001;
  localparam logic [4:0] T_MOV = 5'b00010;
  localparam logic [4:0] T_JMP = 5'b01100;
  localparam logic [4:0] T_JC  = 5'b01101;
  localparam logic [4:0] T_JZ  = 5'b10001;
  localparam logic [4:0] T_HLT = 5'b10111;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        imem_rd_en;
  logic [7:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] ir;
  logic        ir_valid;
  logic        ir_ready;
  logic        ex_done = 1'b0;
  logic        fs = 1'b0;
  logic        fz = 1'b0;
  logic        fc = 1'b0;
  logic        fv = 1'b0;
  logic [7:0]  pc;
  logic        halted;
  logic        busy;

  always #5 clk = ~clk;

  instr_fetch_seq #(.ADDR_W(8), .START_ADDR(8'h00)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .imem_rd_en    (imem_rd_en),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .ir            (ir),
    .ir_valid      (ir_valid),
    .ir_ready      (ir_ready),
    .ex_done       (ex_done),
    .flag_sign     (fs),
    .flag_zero     (fz),
    .flag_carry    (fc),
    .flag_overflow (fv),
    .pc            (pc),
    .halted        (halted),
    .busy          (busy)
  );

  logic [31:0] mem [256];
  always @(posedge clk)
    if (imem_rd_en) imem_rdata <= mem[imem_addr];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0]  exp_a [$];
  logic [31:0] exp_w [$];
  int          acc_q [$];
  int          fcyc [256];
  int          done_cyc = 0;
  int          ex_delay = 1;
  int          force_req = 0;
  int          force_ack = 0;
  logic [3:0]  force_flags = 4'h0;
  logic        pend = 1'b0;
  int          cnt = 0;
  logic [3:0]  pflags = 4'h0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %b want %b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] wd(input logic [4:0] op,
                                     input logic [7:0] lo);
    return {op, 19'h12345, lo};
  endfunction

  // Execute model: flags of an op are its low nibble {s,z,c,v}
  always @(negedge clk) begin
    ex_done = 1'b0;
    if (!rst_n) pend = 1'b0;
    if (imem_rd_en) begin
      fcyc[imem_addr] = cyc;
      chk1("fetch_expected", exp_a.size() != 0, 1'b1);
      if (exp_a.size() != 0)
        chk("fetch_addr", {24'h0, imem_addr}, {24'h0, exp_a.pop_front()});
    end
    if (pend) begin
      cnt--;
      if (cnt <= 0) begin
        ex_done = 1'b1;
        {fs, fz, fc, fv} = pflags;
        pend = 1'b0;
        done_cyc = cyc;
      end
    end
    if (force_req != force_ack) begin
      ex_done = 1'b1;
      {fs, fz, fc, fv} = force_flags;
      force_ack = force_req;
    end
    if (rst_n && ir_valid && ir_ready) begin
      chk1("issue_expected", exp_w.size() != 0, 1'b1);
      if (exp_w.size() != 0) chk("issue_ir", ir, exp_w.pop_front());
      acc_q.push_back(cyc);
      pend = 1'b1;
      cnt = ex_delay;
      pflags = ir[3:0];
    end
  end

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = wd(T_HLT, 8'h00);
  endtask

  task automatic push_prog_a();
    exp_a.push_back(8'h00); exp_a.push_back(8'h01);
    exp_a.push_back(8'h02); exp_a.push_back(8'h03);
    exp_a.push_back(8'h20); exp_a.push_back(8'h21);
    exp_a.push_back(8'h40); exp_a.push_back(8'h41);
    exp_a.push_back(8'h42);
    exp_w.push_back(mem[8'h00]); exp_w.push_back(mem[8'h01]);
    exp_w.push_back(mem[8'h02]); exp_w.push_back(mem[8'h20]);
    exp_w.push_back(mem[8'h40]);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  logic [31:0] ir0;
  logic [7:0]  pc0;

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    ir_ready = 1'b1;
    clear_mem();
    repeat (2) tick();
    chk1("rst_rd_en", imem_rd_en, 1'b0);
    chk1("rst_ir_valid", ir_valid, 1'b0);
    chk1("rst_halted", halted, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk("rst_pc", {24'h0, pc}, 32'h0);
    chk("rst_ir", ir, 32'h0);
    rst_n = 1'b1;
    tick();

    // Program A: straight-line, JZ taken/not taken, JMP, HLT
    mem[8'h00] = wd(T_ADD, 8'h10);
    mem[8'h01] = wd(T_MOV, 8'h20);
    mem[8'h02] = wd(T_ADD, 8'h04);
    mem[8'h03] = wd(T_JZ,  8'h20);
    mem[8'h20] = wd(T_MOV, 8'h30);
    mem[8'h21] = wd(T_JMP, 8'h40);
    mem[8'h40] = wd(T_ADD, 8'h50);
    mem[8'h41] = wd(T_JZ,  8'h20);
    mem[8'h42] = wd(T_HLT, 8'h00);
    push_prog_a();
    acc_q.delete();
    pulse_start();
    chk1("start_rd_en", imem_rd_en, 1'b1);
    chk("start_addr", {24'h0, imem_addr}, 32'h0);
    chk1("start_busy", busy, 1'b1);
    for (int n = 0; n < 300 && !halted; n++) tick();
    chk1("haltA", halted, 1'b1);
    chk1("haltA_busy", busy, 1'b0);
    chk("haltA_pc", {24'h0, pc}, 32'h42);
    chk("haltA_fetch_left", exp_a.size(), 0);
    chk("haltA_issue_left", exp_w.size(), 0);
    chk("haltA_issues", acc_q.size(), 5);
    if (acc_q.size() >= 2)
      chk("issue_interval", acc_q[1] - acc_q[0], 3);
    chk("jmp_latency", fcyc[8'h40] - fcyc[8'h21], 2);
    repeat (5) tick();
    chk1("halt_no_fetch", imem_rd_en, 1'b0);
    chk1("halt_hold", halted, 1'b1);

    push_prog_a();
    pulse_start();
    chk1("restart_rd_en", imem_rd_en, 1'b1);
    chk("restart_addr", {24'h0, imem_addr}, 32'h0);
    for (int n = 0; n < 300 && !halted; n++) tick();
    chk1("haltA2", halted, 1'b1);
    chk("haltA2_fetch_left", exp_a.size(), 0);

    // Program B: back-pressure, delayed flags for JC, pc wrap
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    clear_mem();
    mem[8'h00] = wd(T_ADD, 8'h02);
    mem[8'h01] = wd(T_JC,  8'h10);
    mem[8'h10] = wd(T_MOV, 8'h00);
    mem[8'h11] = wd(T_JMP, 8'hFF);
    mem[8'hFF] = wd(T_MOV, 8'h00);
    exp_a.push_back(8'h00); exp_a.push_back(8'h01);
    exp_a.push_back(8'h10); exp_a.push_back(8'h11);
    exp_a.push_back(8'hFF); exp_a.push_back(8'h00);
    exp_w.push_back(mem[8'h00]); exp_w.push_back(mem[8'h10]);
    exp_w.push_back(mem[8'hFF]);
    acc_q.delete();
    ex_delay = 4;
    ir_ready = 1'b0;
    tick();
    pulse_start();
    for (int n = 0; n < 50 && !ir_valid; n++) tick();
    chk1("bp_valid", ir_valid, 1'b1);
    chk("bp_ir", ir, wd(T_ADD, 8'h02));
    ir0 = ir;
    pc0 = pc;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk1("bp_hold_valid", ir_valid, 1'b1);
      chk("bp_hold_ir", ir, ir0);
      chk("bp_hold_pc", {24'h0, pc}, {24'h0, pc0});
    end
    ir_ready = 1'b1;
    tick();
    chk1("bp_release_valid", ir_valid, 1'b0);
    chk("bp_release_pc", {24'h0, pc}, {24'h0, pc0 + 8'h01});
    for (int n = 0; n < 100 && exp_a.size() > 3; n++) tick();
    chk("jc_fetch_seen", exp_a.size(), 3);
    chk("jc_after_done", fcyc[8'h10] - done_cyc, 1);
    if (acc_q.size() >= 1)
      chk("jc_wait_len", fcyc[8'h10] - acc_q[0], 5);
    ex_delay = 1;
    for (int n = 0; n < 100 && exp_w.size() != 0; n++) tick();
    ir_ready = 1'b0;
    chk("wrap_pc", {24'h0, pc}, 32'h0);
    chk1("wrap_rd_en", imem_rd_en, 1'b1);
    chk("wrap_addr", {24'h0, imem_addr}, 32'h0);
    for (int n = 0; n < 50 && !ir_valid; n++) tick();
    chk1("pre_rst_valid", ir_valid, 1'b1);
    rst_n = 1'b0;
    tick();
    chk1("mid_rst_valid", ir_valid, 1'b0);
    chk("mid_rst_pc", {24'h0, pc}, 32'h0);
    chk1("mid_rst_busy", busy, 1'b0);
    chk1("mid_rst_rd_en", imem_rd_en, 1'b0);
    chk("mid_rst_fetch_left", exp_a.size(), 0);

    // Program C: spurious ex_done in IDLE must not set flags
    rst_n = 1'b1;
    ir_ready = 1'b1;
    force_flags = 4'hF;
    force_req++;
    repeat (2) tick();
    clear_mem();
    mem[8'h00] = wd(T_JZ, 8'h30);
    mem[8'h01] = wd(T_JC, 8'h31);
    mem[8'h02] = wd(T_HLT, 8'h00);
    exp_a.push_back(8'h00); exp_a.push_back(8'h01);
    exp_a.push_back(8'h02);
    pulse_start();
    for (int n = 0; n < 100 && !halted; n++) tick();
    chk1("haltC", halted, 1'b1);
    chk("haltC_pc", {24'h0, pc}, 32'h02);
    chk("haltC_fetch_left", exp_a.size(), 0);
    repeat (4) tick();
    chk1("haltC_no_fetch", imem_rd_en, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
